keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart to the stopwatch's multiplexed 7-segment display driver.
- The display driver walks active-low digit selects and drives shared segment lines. This block walks active-low column drives across a 4x4 matrix keypad and reads the shared active-low row lines.
- Debounces the matrix and emits one-cycle key events (code 0-15) that downstream control logic uses for start/stop/lap/reset commands.
- Sits between the board pins and the stopwatch control logic, clocked from the undivided board clock.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; legal range >= 4 so the row synchronizer settles within the dwell.
- DEBOUNCE_SCANS, 3: consecutive identical full scans required to accept a press or a release; legal range 2..15.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- ROW  input  4  keypad rows, active-low (pulled up); asynchronous to CLK.
- COL  output 4  column drives, active-low, exactly one bit low at all times.
- KEY_CODE  output 4  last accepted key, code = col_index*4 + row_index.
- KEY_VALID  output 1  one-cycle pulse on acceptance of a press.
- KEY_HELD  output 1  high while an accepted key is considered pressed.

Behaviour:
- Reset values: COL=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0. Dwell counter=0, column index=0, FSM=IDLE, debounce count=0, snapshot cleared.
- ROW passes through a 2-flop synchronizer. Sampling uses only the synchronized value.
- Dwell counter runs 0..SCAN_DIV-1. On the edge where it equals SCAN_DIV-1:
  - latch the inverted synchronized ROW into snapshot bits [col*4+3:col*4];
  - advance the column index (wraps 3->0);
  - update COL = ~(1<<next_index);
  - reset the dwell counter.
- End-of-scan (EOS) is the column-3 sample edge. One scan = 4*SCAN_DIV cycles.
- EOS classification of the 16-bit snapshot:
  - NONE: zero bits set.
  - SINGLE(k): exactly one bit k set.
  - MULTI: two or more bits set (ghosting); never yields a code.
- FSM, evaluated only at EOS; cnt saturates at 15:
  - IDLE: SINGLE(k) -> PRESS_DEB, cand=k, cnt=1. Otherwise stay.
  - PRESS_DEB: SINGLE(cand) -> cnt+1; when the new cnt equals DEBOUNCE_SCANS, register KEY_CODE=cand, pulse KEY_VALID, go to HELD. SINGLE(j!=cand) -> cand=j, cnt=1. NONE or MULTI -> IDLE.
  - HELD: NONE -> RELEASE_DEB, cnt=1. SINGLE or MULTI -> stay; no new event even if a different key appears.
  - RELEASE_DEB: NONE -> cnt+1; when the new cnt equals DEBOUNCE_SCANS, go to IDLE. SINGLE or MULTI -> HELD.
- Outputs:
  - KEY_VALID and the KEY_CODE update are registered on the accepting EOS edge. KEY_VALID is high for exactly the following cycle.
  - KEY_CODE holds its value until the next acceptance.
  - KEY_HELD = state in {HELD, RELEASE_DEB}.
- Snapshot and classification are rebuilt every scan; no history beyond cand/cnt.
- RST mid-scan or mid-debounce forces all reset values on the next edge and drops any pending candidate. A key held through reset must re-debounce and then produces a fresh KEY_VALID.
- Press-to-event latency: DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 scans, plus 2-cycle sync delay.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_SCANS=3; key (col 1, row 2) held from reset release; number rising edges from the first edge with RST low as edge 1 -> COL sequence 1110,1101,1011,0111 switching at edges 4,8,12,16. KEY_VALID high only in the cycle after edge 48, KEY_CODE=6, KEY_HELD=1 from that cycle.
- Same press, then release -> KEY_HELD falls after the 3rd consecutive NONE scan. No KEY_VALID at release. KEY_CODE stays 6.
- Bounce: key 9 present for 2 scans, absent 1, present 3 -> exactly one KEY_VALID (code 9), at the end of the final 3-scan run.
- Keys 0 and 5 pressed together for 10 scans -> no KEY_VALID, KEY_HELD=0. Then key 0 alone for 3 scans -> KEY_VALID, code 0.
- Key 3 accepted; key 12 pressed while 3 still held, then 3 released -> no event for 12 until all keys are released for 3 scans and 12 is re-pressed.
- RST asserted for 1 cycle during PRESS_DEB (cnt=2) -> COL=1110 and all outputs 0 next cycle. Continued hold gives KEY_VALID 48 cycles after reset release.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low column drives, samples synchronized
// active-low rows, debounces whole-matrix scans and emits one-cycle key events.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    RELEASE_DEB
  } state_t;

  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [1:0]    next_idx;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [15:0]   snapshot;
  logic [15:0]   snap_next;
  logic          sample;
  logic          eos;

  logic [4:0]    bit_cnt;
  logic [3:0]    hit_code;
  logic          is_none;
  logic          is_single;

  state_t        state;
  logic [3:0]    cand;
  logic [3:0]    cnt;
  logic [3:0]    cnt_inc;

  // Classification sees the snapshot including the column being latched this edge,
  // so the EOS decision covers the full scan that just completed.
  always_comb begin
    sample    = (dwell == DWELL_LAST);
    eos       = sample && (col_idx == 2'd3);
    next_idx  = col_idx + 2'd1;
    snap_next = snapshot;
    if (sample) begin
      snap_next[{col_idx, 2'b00} +: 4] = ~row_sync;
    end
  end

  always_comb begin
    bit_cnt  = '0;
    hit_code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (snap_next[i]) begin
        bit_cnt  = bit_cnt + 5'd1;
        hit_code = 4'(i);
      end
    end
    is_none   = (bit_cnt == 5'd0);
    is_single = (bit_cnt == 5'd1);
    cnt_inc   = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_meta <= '1;
      row_sync <= '1;
      dwell    <= '0;
      col_idx  <= '0;
      COL      <= 4'b1110;
      snapshot <= '0;
    end else begin
      row_meta <= ROW;
      row_sync <= row_meta;
      if (sample) begin
        dwell    <= '0;
        col_idx  <= next_idx;
        COL      <= ~(4'b0001 << next_idx);
        snapshot <= snap_next;
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      KEY_CODE  <= '0;
      KEY_VALID <= 1'b0;
      KEY_HELD  <= 1'b0;
    end else begin
      KEY_VALID <= 1'b0;
      if (eos) begin
        unique case (state)
          IDLE: begin
            if (is_single) begin
              state <= PRESS_DEB;
              cand  <= hit_code;
              cnt   <= 4'd1;
            end
          end
          PRESS_DEB: begin
            if (is_single && (hit_code == cand)) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_TARGET) begin
                KEY_CODE  <= cand;
                KEY_VALID <= 1'b1;
                KEY_HELD  <= 1'b1;
                state     <= HELD;
              end
            end else if (is_single) begin
              cand <= hit_code;
              cnt  <= 4'd1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (is_none) begin
              state <= RELEASE_DEB;
              cnt   <= 4'd1;
            end
          end
          RELEASE_DEB: begin
            if (is_none) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_TARGET) begin
                state    <= IDLE;
                KEY_HELD <= 1'b0;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix drives ROW from COL,
// and each step checks outputs at hand-computed clock edges (SCAN_DIV=4, 3 scans).
module tb_keypad_scanner;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_HELD;

  logic [15:0] keys = '0;
  int unsigned edge_no = 0;
  int unsigned vcount = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ROW(ROW),
    .COL(COL),
    .KEY_CODE(KEY_CODE),
    .KEY_VALID(KEY_VALID),
    .KEY_HELD(KEY_HELD)
  );

  always #5 CLK = ~CLK;

  // Pressed key at (col c, row r) pulls row r low while column c is driven low.
  always_comb begin
    ROW = '1;
    for (int c = 0; c < 4; c++) begin
      if (!COL[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4 + r]) ROW[r] = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (KEY_VALID) vcount <= vcount + 1;
  end

  task automatic go_to(input int unsigned target);
    while (edge_no < target) begin
      @(posedge CLK);
      edge_no++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_col", COL, 4'b1110);
    chk("rst_code", KEY_CODE, 4'd0);
    chk("rst_valid", KEY_VALID, 1'b0);
    chk("rst_held", KEY_HELD, 1'b0);

    // Key 6 held from reset release
    keys = 16'h0040;
    RST = 1'b0;
    edge_no = 0;
    go_to(3);  chk("col_e3", COL, 4'b1110);
    go_to(4);  chk("col_e4", COL, 4'b1101);
    go_to(8);  chk("col_e8", COL, 4'b1011);
    go_to(12); chk("col_e12", COL, 4'b0111);
    go_to(16); chk("col_e16", COL, 4'b1110);
    go_to(47);
    chk("k6_valid_e47", KEY_VALID, 1'b0);
    chk("k6_held_e47", KEY_HELD, 1'b0);
    go_to(48);
    chk("k6_valid_e48", KEY_VALID, 1'b1);
    chk("k6_code_e48", KEY_CODE, 4'd6);
    chk("k6_held_e48", KEY_HELD, 1'b1);
    go_to(49);
    chk("k6_valid_e49", KEY_VALID, 1'b0);
    chk("k6_held_e49", KEY_HELD, 1'b1);

    // Release: three NONE scans ending at 64, 80, 96
    keys = '0;
    go_to(95);
    chk("rel_held_e95", KEY_HELD, 1'b1);
    go_to(96);
    chk("rel_held_e96", KEY_HELD, 1'b0);
    chk("rel_code_e96", KEY_CODE, 4'd6);
    chk("rel_vcount", vcount, 1);

    // Bounce on key 9: 2 scans, 1 gap, 3 scans -> accept at 192
    keys = 16'h0200;
    go_to(128); keys = '0;
    go_to(144); keys = 16'h0200;
    go_to(191);
    chk("b9_valid_e191", KEY_VALID, 1'b0);
    chk("b9_vcount_e191", vcount, 1);
    go_to(192);
    chk("b9_valid_e192", KEY_VALID, 1'b1);
    chk("b9_code_e192", KEY_CODE, 4'd9);
    keys = '0;

    // Ghost pair 0+5 for 10 scans, then key 0 alone
    go_to(240); keys = 16'h0021;
    go_to(400);
    chk("ghost_held", KEY_HELD, 1'b0);
    chk("ghost_vcount", vcount, 2);
    keys = 16'h0001;
    go_to(447); chk("k0_valid_e447", KEY_VALID, 1'b0);
    go_to(448);
    chk("k0_valid_e448", KEY_VALID, 1'b1);
    chk("k0_code_e448", KEY_CODE, 4'd0);
    keys = '0;

    // Key 3 accepted, 12 rolled over while held, then full release and re-press
    go_to(496); keys = 16'h0008;
    go_to(544);
    chk("k3_valid_e544", KEY_VALID, 1'b1);
    chk("k3_code_e544", KEY_CODE, 4'd3);
    keys = 16'h1008;
    go_to(576); keys = 16'h1000;
    go_to(640);
    chk("roll_held", KEY_HELD, 1'b1);
    chk("roll_code", KEY_CODE, 4'd3);
    chk("roll_vcount", vcount, 4);
    keys = '0;
    go_to(688);
    chk("roll_rel_held", KEY_HELD, 1'b0);
    keys = 16'h1000;
    go_to(735); chk("k12_valid_e735", KEY_VALID, 1'b0);
    go_to(736);
    chk("k12_valid_e736", KEY_VALID, 1'b1);
    chk("k12_code_e736", KEY_CODE, 4'd12);
    keys = '0;

    // Reset during PRESS_DEB (cnt=2 after scan 816)
    go_to(784); keys = 16'h0040;
    go_to(820);
    RST = 1'b1;
    go_to(821);
    chk("mid_rst_col", COL, 4'b1110);
    chk("mid_rst_code", KEY_CODE, 4'd0);
    chk("mid_rst_valid", KEY_VALID, 1'b0);
    chk("mid_rst_held", KEY_HELD, 1'b0);
    RST = 1'b0;
    edge_no = 0;
    go_to(47);
    chk("rr_valid_e47", KEY_VALID, 1'b0);
    go_to(48);
    chk("rr_valid_e48", KEY_VALID, 1'b1);
    chk("rr_code_e48", KEY_CODE, 4'd6);
    go_to(50);
    chk("rr_vcount", vcount, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
